bram_stream_reader: RTL
=======================

Name: bram_stream_reader

Overview:
- Read-side controller for the team's simple dual-port block RAM, which has a registered read with 1-cycle latency. On a start command it sweeps a strided address sequence over the RAM read port and turns the returned words into a valid/ready stream with a last-beat marker.
- It absorbs the RAM read latency with a 2-entry output FIFO and credit-based read issue. Throughput is 1 word/clk when the consumer never stalls, and no word is lost or duplicated under backpressure.
- It sits between coefficient RAMs and downstream arithmetic or streaming-out stages.

Parameters:
- DLEN, 32, data word width; must match the RAM DLEN.
- HLEN, 5, address width; RAM depth is 2^HLEN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  1-cycle command pulse; sampled only in IDLE.
- base_addr  input  HLEN  first read address; sampled with start.
- stride  input  HLEN  address increment; sampled with start.
- len  input  HLEN+1  number of words to read, 0..2^HLEN; sampled with start.
- raddr  output  HLEN  registered read address driven to the RAM read port.
- rdata  input  DLEN  RAM dout; valid 1 clk after the matching raddr.
- m_data  output  DLEN  stream data; the head of the FIFO.
- m_valid  output  1  stream valid.
- m_last  output  1  high with the final beat of a command.
- m_ready  input  1  consumer ready; a beat transfers when m_valid and m_ready are both high.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  1-cycle pulse when the command completes.

Behaviour:
- Reset values: raddr=0, m_valid=0, m_last=0, m_data=0, busy=0, done=0. The state machine returns to IDLE and the FIFO, in-flight flag and counters clear.
- Reset mid-command aborts the command immediately. No further beats and no done pulse follow.
- States:
  - IDLE: on start with len>0, go to RUN and set busy=1. On start with len=0, pulse done in the next cycle, stay IDLE, busy stays 0.
  - RUN: issue reads. After the last read has been issued, go to DRAIN.
  - DRAIN: wait until the last beat is accepted. Then pulse done, go to IDLE, busy=0.
- start outside IDLE is ignored, including in the cycle done is high.
- Addressing: the k-th read address is (base_addr + k*stride) mod 2^HLEN, for k=0..len-1. The address accumulates with plain HLEN-bit wrap and no saturation; stride=0 rereads base_addr.
- Read issue: at most one read per cycle. A read "issues" in a cycle where raddr holds a new address and the issue flag is set.
- Credit rule: a read may be issued in cycle t only if fifo_count(t) + inflight(t) - pop(t) < 2, where pop(t) = m_valid & m_ready.
- The word issued at cycle t is written into the FIFO at the end of cycle t+1 from rdata, so the FIFO can never overflow.
- When not issuing, raddr holds its value.
- Latency: start is sampled at the edge ending cycle 0.
  - raddr = base_addr in cycle 1.
  - rdata is valid in cycle 2.
  - m_valid = 1 in cycle 3.
- Throughput: with m_ready held high, one beat per cycle. len words need len+2 cycles from the first raddr to the last beat.
- Backpressure: when m_ready=0, m_valid, m_data and m_last stay stable until accepted. Reads stop once the credit is exhausted (FIFO holds 2, or holds 1 with 1 in flight).
- FIFO empty gives m_valid=0. A simultaneous push and pop keeps the count unchanged.
- m_last is carried per FIFO entry and is set on the entry for k=len-1.
- done is asserted in the cycle after the m_last beat transfers. busy falls in that same cycle.
- len=2^HLEN reads every address once; the counter is HLEN+1 bits.

Test Plan:
- Basic sweep: HLEN=5, RAM preloaded mem[i]=i+100; base=0, stride=1, len=4, m_ready=1 -> beats 100,101,102,103 on cycles 3..6, m_last on 103, done on cycle 7.
- Wrap and stride: base=30, stride=3, len=4 -> addresses 30,1,4,7 in order; data mem[30],mem[1],mem[4],mem[7].
- Backpressure: len=8; m_ready toggles 1,0,0,1 repeating and also randomly -> exactly 8 beats in address order, no duplicates or drops; raddr stalls with FIFO plus in-flight never exceeding 2; m_data stable while stalled.
- Edge lengths: len=0 -> done 1 cycle after start, m_valid never high. len=32 with stride=1 -> all 32 words, m_last on mem[base-1 mod 32].
- Ignored start and abort:
  - A start pulse during RUN, with different base, is ignored and the output matches the first command.
  - reset asserted on the 3rd beat -> m_valid=0, busy=0 immediately, no done pulse.
  - A new command after reset runs correctly.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Read-side controller for a simple dual-port block RAM with a 1-cycle
// registered read. A start command sweeps base + k*stride over the read port.
// The returned words leave as a valid/ready stream with a last-beat marker.
// A 2-entry output FIFO with credit-based issue absorbs the RAM latency.
// raddr is the address register itself. The RAM reads it every cycle, and the
// issue flag marks which returned words belong to the stream.
module bram_stream_reader #(
  parameter int DLEN = 32,
  parameter int HLEN = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [HLEN-1:0] base_addr,
  input  logic [HLEN-1:0] stride,
  input  logic [HLEN:0]   len,
  output logic [HLEN-1:0] raddr,
  input  logic [DLEN-1:0] rdata,
  output logic [DLEN-1:0] m_data,
  output logic            m_valid,
  output logic            m_last,
  input  logic            m_ready,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [HLEN:0] ONE = (HLEN+1)'(1);

  logic [1:0]      state;
  logic [HLEN-1:0] stride_q;
  logic [HLEN:0]   remaining;      // reads still to issue, including the one at raddr
  logic            inflight;       // a read issued last cycle returns on rdata now
  logic            inflight_last;  // that read carries the final word

  logic [DLEN-1:0] fifo_data [2];  // entry 0 is the head
  logic [1:0]      fifo_last;
  logic [1:0]      fifo_count;

  logic       issue;
  logic       last_issue;
  logic       pop;
  logic       push;
  logic       last_pop;
  logic       accept;
  logic       wr_slot0;
  logic [2:0] occupancy;

  // Issue, transfer and command-accept decisions for the current cycle.
  // NOTE: every signal gets a value on every path through always_comb; a
  // missing default would infer a latch.
  always_comb begin
    pop        = m_valid & m_ready;
    push       = inflight;
    last_pop   = pop & m_last;
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    issue      = (state == S_RUN) && (remaining != '0) &&
                 (occupancy < (3'd2 + {2'b00, pop}));
    last_issue = issue && (remaining == ONE);
    accept     = start && (state == S_IDLE) && !done;
    wr_slot0   = (fifo_count == 2'd0) || ((fifo_count == 2'd1) && pop);
  end

  // Command FSM, address generation and read tracking.
  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every always_ff reads the pre-edge values of its peers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      raddr         <= '0;
      stride_q      <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= last_issue;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (len != '0) begin
              state     <= S_RUN;
              busy      <= 1'b1;
              raddr     <= base_addr;
              stride_q  <= stride;
              remaining <= len;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            remaining <= remaining - ONE;
            // Hold the final address once it has been issued.
            if (last_issue) state <= S_DRAIN;
            else            raddr <= raddr + stride_q;
          end
        end
        S_DRAIN: begin
          if (last_pop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-entry shift FIFO: a pop shifts entry 1 into the head. A push writes the
  // first free slot after that pop. The credit rule keeps it from overflowing.
  // NOTE: the FIFO storage is reset along with the control because its head
  // drives m_data directly and must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last    <= '0;
      fifo_count   <= '0;
    end else begin
      if (pop) begin
        fifo_data[0] <= fifo_data[1];
        fifo_last[0] <= fifo_last[1];
      end
      if (push) begin
        if (wr_slot0) begin
          fifo_data[0] <= rdata;
          fifo_last[0] <= inflight_last;
        end else begin
          fifo_data[1] <= rdata;
          fifo_last[1] <= inflight_last;
        end
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_data[0];
  assign m_last  = m_valid & fifo_last[0];

endmodule
